// File: rtl/recv_encrypted_pkg.sv
// -----------------------------------------------------------------------------
// recv_encrypted_pkg
// Shared constants, state encoding and the keystream step function for the
// serial word receiver/decryptor.
// -----------------------------------------------------------------------------
package recv_encrypted_pkg;

  // Default word width; the keystream generator is exactly this wide.
  localparam int WORD_SIZE_DEFAULT = 23;

  // Keystream LFSR geometry: x^23 + x^18 + 1, feedback from bits 22 and 17.
  localparam int LFSR_WIDTH  = 23;
  localparam int LFSR_TAP_HI = 22;
  localparam int LFSR_TAP_LO = 17;

  // Counter widths.
  localparam int INDEX_WIDTH  = 13;
  localparam int BITCNT_WIDTH = 6;

  // Receiver control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  // One keystream step: shift left, feed the tap XOR into the LSB.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
    logic w_fb;
    w_fb = s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO];
    return {s[LFSR_WIDTH-2:0], w_fb};
  endfunction

endpackage

// File: rtl/recv_encrypted_if.sv
// -----------------------------------------------------------------------------
// recv_encrypted_if
// Link-side bundle of the receiver.
//   start      : begin reception (driven by the master)
//   serial_in  : serial data, MSB first (driven by the master)
//   word_out   : decrypted word (driven by the receiver)
//   word_valid : one-cycle strobe for word_out/word_index (receiver)
//   word_index : index of the word on word_out (receiver)
//   done       : all words delivered (receiver)
// -----------------------------------------------------------------------------
interface recv_encrypted_if
  import recv_encrypted_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEFAULT
) ();

  logic                   start;
  logic                   serial_in;
  logic [WORD_SIZE-1:0]   word_out;
  logic                   word_valid;
  logic [INDEX_WIDTH-1:0] word_index;
  logic                   done;

  modport master (
    output start,
    output serial_in,
    input  word_out,
    input  word_valid,
    input  word_index,
    input  done
  );

  modport slave (
    input  start,
    input  serial_in,
    output word_out,
    output word_valid,
    output word_index,
    output done
  );

endinterface

// File: rtl/recv_encrypted_lfsr_keystream.sv
// -----------------------------------------------------------------------------
// lfsr_keystream
// 23-bit Fibonacci LFSR supplying one keystream word per received word.
//   clk     : system clock
//   reset   : synchronous active-high, loads seed
//   advance : step the LFSR once on this edge
//   seed    : initial state (must be nonzero)
//   key     : current LFSR state, used as the keystream word
// -----------------------------------------------------------------------------
module lfsr_keystream
  import recv_encrypted_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  input  logic [LFSR_WIDTH-1:0] seed,
  output logic [LFSR_WIDTH-1:0] key
);

  logic [LFSR_WIDTH-1:0] r_state;

  // LFSR state: reload seed on reset, step once per delivered word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= seed;
    end else if (advance) begin
      r_state <= lfsr_next(r_state);
    end else begin
      r_state <= r_state;
    end
  end

  assign key = r_state;

endmodule

// File: rtl/recv_encrypted.sv
// -----------------------------------------------------------------------------
// recv_encrypted
// Serial receiver and decryptor. Samples one bit per clock (MSB first),
// assembles WORD_SIZE-bit words and XORs each with the next keystream word.
//   clk   : system clock
//   reset : synchronous active-high reset, highest priority
//   bus   : recv_encrypted_if.slave (start, serial_in in; word_out,
//           word_valid, word_index, done out)
// Parameters: WORDS (words per message), WORD_SIZE (must be 23),
//             SEED (keystream seed, must be nonzero).
// -----------------------------------------------------------------------------
module recv_encrypted
  import recv_encrypted_pkg::*;
#(
  parameter int                    WORDS     = 153,
  parameter int                    WORD_SIZE = WORD_SIZE_DEFAULT,
  parameter logic [LFSR_WIDTH-1:0] SEED      = 23'h000001
) (
  input  logic              clk,
  input  logic              reset,
  recv_encrypted_if.slave   bus
);

  localparam logic [BITCNT_WIDTH-1:0] BIT_RELOAD = BITCNT_WIDTH'(WORD_SIZE - 1);
  localparam logic [INDEX_WIDTH-1:0]  LAST_IDX   = INDEX_WIDTH'(WORDS - 1);

  // Elaboration-time parameter checks.
  generate
    if (SEED == 23'd0) begin : g_bad_seed
      $error("recv_encrypted: SEED must be nonzero");
    end
    if (WORD_SIZE != LFSR_WIDTH) begin : g_bad_width
      $error("recv_encrypted: WORD_SIZE must equal the 23-bit keystream width");
    end
    if ((WORDS < 1) || (WORDS > (1 << INDEX_WIDTH))) begin : g_bad_words
      $error("recv_encrypted: WORDS out of range for the word index");
    end
  endgenerate

  state_t                  r_state;
  // Only the low WORD_SIZE-1 bits of the shift register are ever read: the
  // completed word is formed from them plus the bit arriving on that edge.
  logic [WORD_SIZE-2:0]    r_shift;
  logic [BITCNT_WIDTH-1:0] r_bit_cnt;
  logic [INDEX_WIDTH-1:0]  r_word_cnt;
  logic [WORD_SIZE-1:0]    r_word_out;
  logic                    r_word_valid;
  logic [INDEX_WIDTH-1:0]  r_word_index;
  logic                    r_done;

  logic [LFSR_WIDTH-1:0]   w_key;
  logic [WORD_SIZE-1:0]    w_word_full;
  logic                    w_word_end;
  logic                    w_last_word;

  // Word completes on the RECV edge where the bit counter has run down.
  assign w_word_full = {r_shift, bus.serial_in};
  assign w_word_end  = (r_state == RECV) && (r_bit_cnt == 6'd0);
  assign w_last_word = (r_word_cnt == LAST_IDX);

  lfsr_keystream u_keystream (
    .clk     (clk),
    .reset   (reset),
    .advance (w_word_end),
    .seed    (SEED),
    .key     (w_key)
  );

  // Receiver FSM with shift register, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= BIT_RELOAD;
      r_word_cnt   <= 13'd0;
      r_word_out   <= '0;
      r_word_valid <= 1'b0;
      r_word_index <= 13'd0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_word_valid <= 1'b0;
          if (bus.start) begin
            // The start edge itself samples nothing.
            r_state   <= RECV;
            r_bit_cnt <= BIT_RELOAD;
          end else begin
            r_state <= IDLE;
          end
        end
        RECV: begin
          r_shift <= w_word_full[WORD_SIZE-2:0];
          if (r_bit_cnt == 6'd0) begin
            r_word_out   <= w_word_full ^ w_key;
            r_word_index <= r_word_cnt;
            r_word_valid <= 1'b1;
            r_word_cnt   <= r_word_cnt + 13'd1;
            r_bit_cnt    <= BIT_RELOAD;
            if (w_last_word) begin
              // done rises together with the last strobe.
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RECV;
            end
          end else begin
            r_word_valid <= 1'b0;
            r_bit_cnt    <= r_bit_cnt - 6'd1;
          end
        end
        DONE: begin
          r_word_valid <= 1'b0;
          r_done       <= 1'b1;
        end
        default: begin
          r_state      <= IDLE;
          r_word_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.word_out   = r_word_out;
  assign bus.word_valid = r_word_valid;
  assign bus.word_index = r_word_index;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_recv_encrypted.sv
// -----------------------------------------------------------------------------
// tb_recv_encrypted
// Directed bench for recv_encrypted: a WORDS=3 instance for the short
// scenarios and a WORDS=153 instance for a full message.
// -----------------------------------------------------------------------------
module tb_recv_encrypted;
  import recv_encrypted_pkg::*;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   err_cnt = 0;
  int   chk_cnt = 0;

  always #5 clk = ~clk;

  recv_encrypted_if #(.WORD_SIZE(23)) if_a ();
  recv_encrypted_if #(.WORD_SIZE(23)) if_b ();

  recv_encrypted #(.WORDS(3), .WORD_SIZE(23), .SEED(23'h000001)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (if_a)
  );

  recv_encrypted #(.WORDS(153), .WORD_SIZE(23), .SEED(23'h000001)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (if_b)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference keystream step: x^23 + x^18 + 1.
  function automatic logic [22:0] key_step(input logic [22:0] s);
    logic [23:0] wide;
    wide = {s, 1'b0};
    wide[0] = s[22] ^ s[17];
    return wide[22:0];
  endfunction

  // Serialize one word MSB first into instance A; optional start pulse.
  task automatic send_word_a(input logic [22:0] w, input int start_bit, output int early_valids);
    early_valids = 0;
    for (int b = 22; b >= 0; b--) begin
      if_a.serial_in = w[b];
      if_a.start     = (b == start_bit);
      tick();
      if ((b != 0) && if_a.word_valid) early_valids++;
    end
    if_a.start = 1'b0;
  endtask

  initial begin
    int ev;
    int nv;
    int nd;
    int ns;
    int done_k;
    int stb_k [3];
    logic [22:0] stb_w [3];
    logic [12:0] stb_i [3];
    logic [22:0] key;
    logic [22:0] plain;
    logic [22:0] cipher;
    logic [31:0] tmp;
    int k;

    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.start = 1'b0;
    if_a.serial_in = 1'b0;
    if_b.start = 1'b0;
    if_b.serial_in = 1'b0;
    tick();
    tick();

    // Reset state
    check_val("rst_word_out", 32'(if_a.word_out), 32'h0);
    check_val("rst_word_valid", 32'(if_a.word_valid), 32'h0);
    check_val("rst_word_index", 32'(if_a.word_index), 32'h0);
    check_val("rst_done", 32'(if_a.done), 32'h0);
    check_val("rst_state", 32'(dut_a.r_state), 32'(IDLE));
    rst_a = 1'b0;

    // Idle hold with toggling serial_in
    nv = 0;
    for (int i = 0; i < 50; i++) begin
      if_a.serial_in = i[0];
      tick();
      if (if_a.word_valid) nv++;
    end
    check_val("idle_valids", 32'(nv), 32'h0);
    check_val("idle_word_cnt", 32'(dut_a.r_word_cnt), 32'h0);
    check_val("idle_state", 32'(dut_a.r_state), 32'(IDLE));

    // Single word, then two more with start pulses during RECV
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    check_val("start_state", 32'(dut_a.r_state), 32'(RECV));
    send_word_a(23'h2AAAAB, -1, ev);
    check_val("w0_early_valid", 32'(ev), 32'h0);
    check_val("w0_valid", 32'(if_a.word_valid), 32'h1);
    check_val("w0_out", 32'(if_a.word_out), 32'h2AAAAA);
    check_val("w0_index", 32'(if_a.word_index), 32'h0);
    check_val("w0_done", 32'(if_a.done), 32'h0);
    send_word_a(23'h123454, 5, ev);
    check_val("w1_early_valid", 32'(ev), 32'h0);
    check_val("w1_valid", 32'(if_a.word_valid), 32'h1);
    check_val("w1_out", 32'(if_a.word_out), 32'h123456);
    check_val("w1_index", 32'(if_a.word_index), 32'h1);
    check_val("w1_done", 32'(if_a.done), 32'h0);
    send_word_a(23'h7FFFFB, 15, ev);
    check_val("w2_early_valid", 32'(ev), 32'h0);
    check_val("w2_valid", 32'(if_a.word_valid), 32'h1);
    check_val("w2_out", 32'(if_a.word_out), 32'h7FFFFF);
    check_val("w2_index", 32'(if_a.word_index), 32'h2);
    check_val("w2_done", 32'(if_a.done), 32'h1);

    // DONE hold: start pulse and toggling data must have no effect
    nv = 0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if_a.serial_in = i[0];
      if_a.start = (i == 10);
      tick();
      if (if_a.word_valid) nv++;
      if (!if_a.done) nd++;
    end
    if_a.start = 1'b0;
    check_val("done_valids", 32'(nv), 32'h0);
    check_val("done_dropped", 32'(nd), 32'h0);
    check_val("done_word_held", 32'(if_a.word_out), 32'h7FFFFF);
    check_val("done_state", 32'(dut_a.r_state), 32'(DONE));

    // Reset mid-word
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    send_word_a(23'h000000, -1, ev);
    check_val("mw_w0_out", 32'(if_a.word_out), 32'h000001);
    for (int b = 22; b > 12; b--) begin
      if_a.serial_in = b[0];
      tick();
    end
    rst_a = 1'b1;
    tick();
    check_val("mw_rst_word_out", 32'(if_a.word_out), 32'h0);
    check_val("mw_rst_valid", 32'(if_a.word_valid), 32'h0);
    check_val("mw_rst_index", 32'(if_a.word_index), 32'h0);
    check_val("mw_rst_done", 32'(if_a.done), 32'h0);
    check_val("mw_rst_state", 32'(dut_a.r_state), 32'(IDLE));
    check_val("mw_rst_word_cnt", 32'(dut_a.r_word_cnt), 32'h0);
    rst_a = 1'b0;
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    send_word_a(23'h155555, -1, ev);
    check_val("mw_restart_valid", 32'(if_a.word_valid), 32'h1);
    check_val("mw_restart_out", 32'(if_a.word_out), 32'h155554);
    check_val("mw_restart_index", 32'(if_a.word_index), 32'h0);

    // All-zero stream: output is the raw keystream
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    if_a.serial_in = 1'b0;
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    ns = 0;
    done_k = -1;
    for (int i = 0; i < 3; i++) begin
      stb_k[i] = -1;
      stb_w[i] = '0;
      stb_i[i] = '0;
    end
    for (int kk = 1; kk <= 110; kk++) begin
      tick();
      if (if_a.word_valid) begin
        if (ns < 3) begin
          stb_k[ns] = kk;
          stb_w[ns] = if_a.word_out;
          stb_i[ns] = if_a.word_index;
        end
        ns++;
      end
      if (if_a.done && (done_k < 0)) done_k = kk;
    end
    check_val("z_strobes", 32'(ns), 32'd3);
    check_val("z_k0", 32'(stb_k[0]), 32'd23);
    check_val("z_k1", 32'(stb_k[1]), 32'd46);
    check_val("z_k2", 32'(stb_k[2]), 32'd69);
    check_val("z_w0", 32'(stb_w[0]), 32'h000001);
    check_val("z_w1", 32'(stb_w[1]), 32'h000002);
    check_val("z_w2", 32'(stb_w[2]), 32'h000004);
    check_val("z_i0", 32'(stb_i[0]), 32'h0);
    check_val("z_i1", 32'(stb_i[1]), 32'h1);
    check_val("z_i2", 32'(stb_i[2]), 32'h2);
    check_val("z_done_k", 32'(done_k), 32'd69);

    // Full 153-word message on instance B
    rst_b = 1'b0;
    if_b.start = 1'b1;
    tick();
    if_b.start = 1'b0;
    key = 23'h000001;
    k = 0;
    for (int n = 0; n < 153; n++) begin
      tmp = 32'(n) * 32'h00002F1B + 32'h0000A5C3;
      plain = tmp[22:0];
      cipher = plain ^ key;
      for (int b = 22; b >= 0; b--) begin
        if_b.serial_in = cipher[b];
        tick();
        k++;
        if (k == 3518) check_val("full_done_early", 32'(if_b.done), 32'h0);
      end
      check_val("full_valid", 32'(if_b.word_valid), 32'h1);
      check_val("full_out", 32'(if_b.word_out), 32'(plain));
      check_val("full_index", 32'(if_b.word_index), 32'(n));
      key = key_step(key);
    end
    check_val("full_done_3519", 32'(if_b.done), 32'h1);
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      if_b.serial_in = i[1];
      tick();
      if (if_b.word_valid) nv++;
    end
    check_val("full_post_valids", 32'(nv), 32'h0);
    check_val("full_post_done", 32'(if_b.done), 32'h1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
